event_sort_q: RTL and testbench

//  Timestamp-ordered event queue for the PHOLD engine; sits between the event-return arbiter (enqueue side)
//  and the dispatch arbiter (dequeue side). Holds pending event messages sorted ascending by timestamp
//  and always presents the minimum-timestamp event at its head, which also feeds GVT computation.

---
 rtl/phold_pkg.sv | 13 +
 rtl/event_sort_q_cell.sv | 70 +++++++
 rtl/event_sort_q.sv | 95 +++++++++
 tb/tb_event_sort_q.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/phold_pkg.sv
// Shared PHOLD message layout: field widths/offsets and the timestamp accessor.
// Pure declarations; no logic, no latency.
package phold_pkg;
    localparam int MSG_WID  = 32;
    localparam int TIME_WID = 16;
    localparam int NB_LPID  = 8;
    localparam int TIME_LSB = 0;
    localparam int LPID_LSB = TIME_LSB + TIME_WID;

    function automatic logic [TIME_WID-1:0] msg_time(input logic [MSG_WID-1:0] msg);
        return msg[TIME_LSB +: TIME_WID];
    endfunction
endpackage

// File: rtl/event_sort_q_cell.sv
// One slot of the sorted array: chooses keep/new/left/right each edge, result visible after the edge.
// No backpressure of its own; the top qualifies enq/deq before they reach the cells.
module event_sort_q_cell #(
    parameter int MSG_WID = phold_pkg::MSG_WID,
    parameter int CMP_WID = phold_pkg::TIME_WID,
    parameter bit FIRST   = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_enq,
    input  logic               i_deq,
    input  logic [MSG_WID-1:0] i_new_dat,
    input  logic               i_left_vld,
    input  logic [MSG_WID-1:0] i_left_dat,
    input  logic               i_left_cmp,
    input  logic               i_right_vld,
    input  logic [MSG_WID-1:0] i_right_dat,
    input  logic               i_right_cmp,
    output logic               o_vld,
    output logic [MSG_WID-1:0] o_dat,
    output logic               o_cmp
);
    logic               r_vld;
    logic [MSG_WID-1:0] r_dat;
    logic               w_nxt_vld;
    logic [MSG_WID-1:0] w_nxt_dat;

    // "<=" keeps equal keys ahead of the newcomer, giving FIFO order among ties
    assign o_cmp = r_vld && (r_dat[CMP_WID-1:0] <= i_new_dat[CMP_WID-1:0]);
    assign o_vld = r_vld;
    assign o_dat = r_dat;

    always_comb begin
        w_nxt_vld = r_vld;
        w_nxt_dat = r_dat;
        if (i_enq && i_deq) begin
            // insertion evaluated on the view already shifted one slot toward the head
            if (i_right_cmp) begin
                w_nxt_vld = i_right_vld;
                w_nxt_dat = i_right_dat;
            end else if (FIRST || o_cmp) begin
                w_nxt_vld = 1'b1;
                w_nxt_dat = i_new_dat;
            end
        end else if (i_enq) begin
            if (!o_cmp) begin
                if (FIRST || i_left_cmp) begin
                    w_nxt_vld = 1'b1;
                    w_nxt_dat = i_new_dat;
                end else begin
                    w_nxt_vld = i_left_vld;
                    w_nxt_dat = i_left_dat;
                end
            end
        end else if (i_deq) begin
            w_nxt_vld = i_right_vld;
            w_nxt_dat = i_right_dat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= 1'b0;
            r_dat <= '0;
        end else begin
            r_vld <= w_nxt_vld;
            r_dat <= w_nxt_dat;
        end
    end
endmodule

// File: rtl/event_sort_q.sv
// Timestamp-sorted event queue; head is the minimum key (FIFO among ties). enq/deq at edge k show after k.
// No backpressure: enq while full (without deq) is dropped and flagged sticky ovf_err; deq on empty sets unf_err.
module event_sort_q #(
    parameter int MSG_WID = phold_pkg::MSG_WID,
    parameter int CMP_WID = phold_pkg::TIME_WID,
    parameter int DEPTH   = 32,
    parameter int NB_CNT  = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enq,
    input  logic               deq,
    input  logic [MSG_WID-1:0] inp_data,
    output logic [MSG_WID-1:0] out_data,
    output logic               full,
    output logic               empty,
    output logic [NB_CNT-1:0]  elem_cnt,
    output logic               ovf_err,
    output logic               unf_err
);
    // index j+1 holds cell j; indices 0 and DEPTH+1 are permanently empty borders
    logic [DEPTH+1:0]   w_vld;
    logic [DEPTH+1:0]   w_cmp;
    logic [MSG_WID-1:0] w_dat [DEPTH+2];

    logic [NB_CNT-1:0]  r_cnt;
    logic               r_ovf;
    logic               r_unf;
    logic               w_full;
    logic               w_empty;
    logic               w_deq_ok;
    logic               w_enq_ok;

    assign w_full   = (r_cnt == NB_CNT'(DEPTH));
    assign w_empty  = (r_cnt == '0);
    assign w_deq_ok = deq && !w_empty;
    assign w_enq_ok = enq && (!w_full || w_deq_ok);

    assign w_vld[0]         = 1'b0;
    assign w_cmp[0]         = 1'b0;
    assign w_dat[0]         = '0;
    assign w_vld[DEPTH+1]   = 1'b0;
    assign w_cmp[DEPTH+1]   = 1'b0;
    assign w_dat[DEPTH+1]   = '0;

    for (genvar g = 0; g < DEPTH; g++) begin : g_cell
        event_sort_q_cell #(
            .MSG_WID (MSG_WID),
            .CMP_WID (CMP_WID),
            .FIRST   (g == 0)
        ) u_cell (
            .clk         (clk),
            .rst_n       (rst_n),
            .i_enq       (w_enq_ok),
            .i_deq       (w_deq_ok),
            .i_new_dat   (inp_data),
            .i_left_vld  (w_vld[g]),
            .i_left_dat  (w_dat[g]),
            .i_left_cmp  (w_cmp[g]),
            .i_right_vld (w_vld[g+2]),
            .i_right_dat (w_dat[g+2]),
            .i_right_cmp (w_cmp[g+2]),
            .o_vld       (w_vld[g+1]),
            .o_dat       (w_dat[g+1]),
            .o_cmp       (w_cmp[g+1])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_ovf <= 1'b0;
            r_unf <= 1'b0;
        end else begin
            if (w_enq_ok && !w_deq_ok) begin
                r_cnt <= r_cnt + 1'b1;
            end else if (w_deq_ok && !w_enq_ok) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (enq && w_full && !deq) begin
                r_ovf <= 1'b1;
            end
            if (deq && w_empty) begin
                r_unf <= 1'b1;
            end
        end
    end

    assign out_data = w_dat[1];
    assign full     = w_full;
    assign empty    = w_empty;
    assign elem_cnt = r_cnt;
    assign ovf_err  = r_ovf;
    assign unf_err  = r_unf;
endmodule

// File: tb/tb_event_sort_q.sv
// Bench for event_sort_q: queue-based reference model checked every cycle, plus directed literal checks.
module tb_event_sort_q;
    import phold_pkg::*;

    localparam int DEPTH = 32;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               enq = 1'b0;
    logic               deq = 1'b0;
    logic [MSG_WID-1:0] inp_data = '0;
    logic [MSG_WID-1:0] out_data;
    logic               full;
    logic               empty;
    logic [5:0]         elem_cnt;
    logic               ovf_err;
    logic               unf_err;

    event_sort_q dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enq      (enq),
        .deq      (deq),
        .inp_data (inp_data),
        .out_data (out_data),
        .full     (full),
        .empty    (empty),
        .elem_cnt (elem_cnt),
        .ovf_err  (ovf_err),
        .unf_err  (unf_err)
    );

    always #5 clk = ~clk;

    // reference model: a plain sorted list plus the two sticky flags
    logic [MSG_WID-1:0] mq[$];
    bit                 m_ovf = 1'b0;
    bit                 m_unf = 1'b0;
    bit                 chk_en = 1'b0;
    int                 n_chk = 0;
    int                 n_fail = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endfunction

    task automatic model_update(input bit e, input bit d, input logic [MSG_WID-1:0] m);
        bit de;
        bit ee;
        int idx;
        de = d && (mq.size() > 0);
        ee = e && ((mq.size() < DEPTH) || de);
        if (d && mq.size() == 0) m_unf = 1'b1;
        if (e && mq.size() == DEPTH && !d) m_ovf = 1'b1;
        if (de) void'(mq.pop_front());
        if (ee) begin
            idx = mq.size();
            for (int i = 0; i < mq.size(); i++) begin
                if (msg_time(mq[i]) > msg_time(m)) begin
                    idx = i;
                    break;
                end
            end
            mq.insert(idx, m);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("head", out_data, (mq.size() > 0) ? mq[0] : 32'd0);
            chk("elem_cnt", 32'(elem_cnt), 32'(mq.size()));
            chk("full", 32'(full), 32'(mq.size() == DEPTH));
            chk("empty", 32'(empty), 32'(mq.size() == 0));
            chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
            chk("unf_err", 32'(unf_err), 32'(m_unf));
        end
    end

    task automatic step(input bit e, input bit d, input logic [MSG_WID-1:0] m);
        enq = e;
        deq = d;
        inp_data = m;
        @(posedge clk);
        model_update(e, d, m);
        @(negedge clk);
        enq = 1'b0;
        deq = 1'b0;
        inp_data = '0;
    endtask

    function automatic logic [MSG_WID-1:0] mk(input int lp, input int t);
        logic [MSG_WID-1:0] m;
        m = '0;
        m[LPID_LSB +: NB_LPID] = NB_LPID'(lp);
        m[TIME_LSB +: TIME_WID] = TIME_WID'(t);
        return m;
    endfunction

    initial begin
        int exp_ord[4];
        int p_enq;
        logic [MSG_WID-1:0] rm;
        exp_ord = '{10, 20, 30, 40};

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_elem_cnt", 32'(elem_cnt), 32'd0);
        chk("rst_ovf", 32'(ovf_err), 32'd0);
        chk("rst_unf", 32'(unf_err), 32'd0);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // ordering
        step(1, 0, mk(0, 40));
        step(1, 0, mk(0, 10));
        step(1, 0, mk(0, 30));
        step(1, 0, mk(0, 20));
        for (int i = 0; i < 4; i++) begin
            chk("order_head", 32'(msg_time(out_data)), 32'(exp_ord[i]));
            step(0, 1, '0);
        end
        chk("order_empty", 32'(empty), 32'd1);

        // equal keys leave in arrival order
        step(1, 0, mk(3, 50));
        step(1, 0, mk(7, 50));
        chk("tie_first_lp", 32'(out_data[LPID_LSB +: NB_LPID]), 32'd3);
        step(0, 1, '0);
        chk("tie_second_lp", 32'(out_data[LPID_LSB +: NB_LPID]), 32'd7);
        step(0, 1, '0);

        // simultaneous enq+deq
        step(1, 0, mk(0, 5));
        step(1, 0, mk(0, 15));
        step(1, 1, mk(0, 8));
        chk("simul_head", 32'(msg_time(out_data)), 32'd8);
        chk("simul_cnt", 32'(elem_cnt), 32'd2);
        step(0, 1, '0);
        chk("simul_next", 32'(msg_time(out_data)), 32'd15);
        step(0, 1, '0);

        // full boundary
        for (int k = 0; k < DEPTH; k++) step(1, 0, mk(0, k));
        chk("full_flag", 32'(full), 32'd1);
        step(1, 0, mk(0, 100));
        chk("full_drop_ovf", 32'(ovf_err), 32'd1);
        chk("full_drop_cnt", 32'(elem_cnt), 32'd32);
        chk("full_drop_head", 32'(msg_time(out_data)), 32'd0);
        step(1, 1, mk(0, 100));
        chk("full_swap_head", 32'(msg_time(out_data)), 32'd1);
        chk("full_swap_full", 32'(full), 32'd1);
        for (int k = 0; k < DEPTH - 1; k++) step(0, 1, '0);
        chk("full_last_head", 32'(msg_time(out_data)), 32'd100);
        step(0, 1, '0);
        chk("full_drained", 32'(empty), 32'd1);

        // empty boundary
        step(0, 1, '0);
        chk("empty_unf", 32'(unf_err), 32'd1);
        chk("empty_cnt", 32'(elem_cnt), 32'd0);
        step(1, 1, mk(0, 7));
        chk("empty_enqdeq_cnt", 32'(elem_cnt), 32'd1);
        chk("empty_enqdeq_head", 32'(msg_time(out_data)), 32'd7);

        // asynchronous reset mid-cycle with contents and sticky flags set
        step(1, 0, mk(1, 3));
        chk_en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cnt", 32'(elem_cnt), 32'd0);
        chk("arst_out", out_data, 32'd0);
        chk("arst_ovf", 32'(ovf_err), 32'd0);
        chk("arst_unf", 32'(unf_err), 32'd0);
        chk("arst_empty", 32'(empty), 32'd1);
        mq.delete();
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_en = 1'b1;

        // randomized traffic with phases of varying enq pressure
        for (int c = 0; c < 4000; c++) begin
            if (c % 400 == 0) p_enq = 20 + 20 * int'($urandom_range(0, 3));
            rm = $urandom;
            rm[TIME_LSB +: TIME_WID] = TIME_WID'($urandom_range(0, 40));
            step(($urandom_range(0, 99) < p_enq), ($urandom_range(0, 99) < 100 - p_enq), rm);
        end

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
